// File: rtl/stopwatch_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_cmd_ctrl
//
// Purpose:
//   Turns two raw push buttons into one-cycle commands for a stopwatch core
//   and keeps a small buffer of lap times.
//     - btn_ss (start/stop): IDLE->RUN (start), RUN->PAUSE (stop),
//       PAUSE->RUN (start).
//     - btn_lr (lap/reset): in RUN it stores the current time as a lap. In
//       PAUSE it issues reset, clears the lap buffer and returns to IDLE.
//       In IDLE it is ignored.
//   Each button goes through a 2-flop synchronizer, then a debouncer. After
//   that a rising-edge detector produces one event per press.
//
// Ports:
//   clk           in   1   single clock
//   rst_n         in   1   asynchronous active-low reset
//   btn_ss        in   1   raw start/stop button (asynchronous)
//   btn_lr        in   1   raw lap/reset button (asynchronous)
//   sw_minutes    in   7   current stopwatch minutes
//   sw_seconds    in   6   current stopwatch seconds
//   lap_rd_idx    in   2   lap buffer read index
//   start         out  1   one-cycle start command (registered)
//   stop          out  1   one-cycle stop command (registered)
//   reset         out  1   one-cycle reset command (registered)
//   ctl_state     out  2   controller state: 00 IDLE, 01 RUN, 10 PAUSE
//   lap_count     out  3   number of stored laps, 0..4
//   lap_overflow  out  1   sticky: a lap was dropped because the buffer was full
//   lap_rd_data   out  13  {minutes, seconds} of lap lap_rd_idx, or 0 if unused
//
// Handshake / timing:
//   There is no valid/ready handshake. A command is a single-cycle pulse on
//   exactly one of start/stop/reset. The stopwatch core must act on it in the
//   cycle it is high.
//   Latency from the first clock edge that samples a held button high to the
//   command pulse (or lap write) is DEBOUNCE_CYCLES+3 cycles. The stages are:
//     - 1 edge: the second synchronizer flop.
//     - DEBOUNCE_CYCLES edges: stable samples.
//     - 1 edge: the registered edge event.
//     - 1 edge: the registered command and lap write.
// -----------------------------------------------------------------------------
module stopwatch_cmd_ctrl #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        btn_ss,
   input  logic        btn_lr,
   input  logic [6:0]  sw_minutes,
   input  logic [5:0]  sw_seconds,
   input  logic [1:0]  lap_rd_idx,
   output logic        start,
   output logic        stop,
   output logic        reset,
   output logic [1:0]  ctl_state,
   output logic [2:0]  lap_count,
   output logic        lap_overflow,
   output logic [12:0] lap_rd_data
);

   // Button index 0 is start/stop and index 1 is lap/reset.
   localparam int BTN_SS = 0;
   localparam int BTN_LR = 1;

   // The debounce counter counts consecutive differing samples. The level
   // flips on the DEBOUNCE_CYCLES-th sample, which is when the counter already
   // holds DEBOUNCE_CYCLES-1.
   localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

   localparam logic [2:0] LAPS_MAX = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10
   } state_t;

   // ---------------------------------------------------------------------
   // Input conditioning: synchronizer, debouncer, rising-edge event
   // ---------------------------------------------------------------------
   logic [1:0] w_btn_raw;
   logic [1:0] r_sync1;
   logic [1:0] r_sync2;
   logic [1:0] r_level;
   logic [1:0] r_level_d;
   logic [1:0] r_evt;
   logic [7:0] r_cnt [2];

   assign w_btn_raw = {btn_lr, btn_ss};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1   <= '0;
         r_sync2   <= '0;
         r_level   <= '0;
         r_level_d <= '0;
         r_evt     <= '0;
         for (int b = 0; b < 2; b++) begin
            r_cnt[b] <= '0;
         end
      end else begin
         r_sync1   <= w_btn_raw;
         r_sync2   <= r_sync1;
         r_level_d <= r_level;
         // An event is registered, so it is one clean cycle per press.
         // Release (falling level) never makes an event.
         r_evt     <= r_level & ~r_level_d;
         for (int b = 0; b < 2; b++) begin
            if (r_sync2[b] == r_level[b]) begin
               // A sample equal to the current level breaks any run of
               // differing samples.
               r_cnt[b] <= '0;
            end else if (r_cnt[b] == CNT_MAX) begin
               r_level[b] <= r_sync2[b];
               r_cnt[b]   <= '0;
            end else begin
               r_cnt[b] <= r_cnt[b] + 8'd1;
            end
         end
      end
   end

   logic w_ss_evt;
   logic w_lr_evt;

   assign w_ss_evt = r_evt[BTN_SS];
   assign w_lr_evt = r_evt[BTN_LR];

   // ---------------------------------------------------------------------
   // Controller FSM
   // ---------------------------------------------------------------------
   state_t r_state;
   state_t w_state_nxt;
   logic   w_start_nxt;
   logic   w_stop_nxt;
   logic   w_reset_nxt;
   logic   w_lap_wr;
   logic   w_lap_ovf_set;
   logic   w_lap_clear;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_start_nxt   = 1'b0;
      w_stop_nxt    = 1'b0;
      w_reset_nxt   = 1'b0;
      w_lap_wr      = 1'b0;
      w_lap_ovf_set = 1'b0;
      w_lap_clear   = 1'b0;
      // In every state the start/stop event is checked first. An lr event
      // in the same cycle only reaches the else branch, so it is dropped.
      case (r_state)
         ST_IDLE: begin
            if (w_ss_evt) begin
               w_state_nxt = ST_RUN;
               w_start_nxt = 1'b1;
            end
         end
         ST_RUN: begin
            if (w_ss_evt) begin
               w_state_nxt = ST_PAUSE;
               w_stop_nxt  = 1'b1;
            end else if (w_lr_evt) begin
               if (r_lap_count == LAPS_MAX) begin
                  w_lap_ovf_set = 1'b1;
               end else begin
                  w_lap_wr = 1'b1;
               end
            end
         end
         ST_PAUSE: begin
            if (w_ss_evt) begin
               w_state_nxt = ST_RUN;
               w_start_nxt = 1'b1;
            end else if (w_lr_evt) begin
               w_state_nxt = ST_IDLE;
               w_reset_nxt = 1'b1;
               w_lap_clear = 1'b1;
            end
         end
         default: begin
            // Encoding 11 is unused. It returns to IDLE silently.
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Registered command outputs
   // ---------------------------------------------------------------------
   logic r_start;
   logic r_stop;
   logic r_reset;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_start <= 1'b0;
         r_stop  <= 1'b0;
         r_reset <= 1'b0;
      end else begin
         r_start <= w_start_nxt;
         r_stop  <= w_stop_nxt;
         r_reset <= w_reset_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // Lap buffer
   // ---------------------------------------------------------------------
   logic [12:0] r_lap [4];
   logic [2:0]  r_lap_count;
   logic        r_lap_ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lap_count <= '0;
         r_lap_ovf   <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            r_lap[i] <= '0;
         end
      end else if (w_lap_clear) begin
         r_lap_count <= '0;
         r_lap_ovf   <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            r_lap[i] <= '0;
         end
      end else if (w_lap_wr) begin
         // Writes append in order. A write only happens when the count is
         // below 4, so the low two bits always address a free slot.
         r_lap[r_lap_count[1:0]] <= {sw_minutes, sw_seconds};
         r_lap_count             <= r_lap_count + 3'd1;
      end else if (w_lap_ovf_set) begin
         r_lap_ovf <= 1'b1;
      end
   end

   // Read port: entries at or beyond the fill level read as zero.
   logic [12:0] w_lap_rd_data;

   always_comb begin
      w_lap_rd_data = '0;
      if ({1'b0, lap_rd_idx} < r_lap_count) begin
         w_lap_rd_data = r_lap[lap_rd_idx];
      end
   end

   // ---------------------------------------------------------------------
   // Output assignments
   // ---------------------------------------------------------------------
   assign start        = r_start;
   assign stop         = r_stop;
   assign reset        = r_reset;
   assign ctl_state    = r_state;
   assign lap_count    = r_lap_count;
   assign lap_overflow = r_lap_ovf;
   assign lap_rd_data  = w_lap_rd_data;

endmodule
